vec_mem_unit: RTL and testbench

- Multi-cycle vector load/store sequencer for the vector datapath.
- The ALU produces the effective address for VLD/VST. This block takes that address and moves one 256-bit vector (16 x 16-bit elements) between the vector register path and a 16-bit-wide word memory, one element per cycle.
- It is the memory-side counterpart of the ALU address computation:
  - reader for VLD (memory -> vector);
  - writer for VST (vector -> memory).

---
 rtl/vec_mem_unit_if.sv | 28 ++
 rtl/vec_mem_unit.sv | 126 ++++++++++++
 tb/tb_vec_mem_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_unit_if.sv
// Word-memory bus between the vector load/store sequencer and memory.
// master drives address/strobes/write data; slave returns read data.
interface vec_mem_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vec_mem_unit.sv
// Vector load/store sequencer: one element per cycle to/from word memory.
// Optional strided addressing when VMEM_STRIDE_EN is defined.
module vec_mem_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ELEMS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ELEMS*DATA_W-1:0] store_data,
`ifdef VMEM_STRIDE_EN
  input  logic [7:0]              stride,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [ELEMS*DATA_W-1:0] load_data,
  vec_mem_unit_if.master          mem
);

  localparam int IW = $clog2(ELEMS);
  localparam int VW = ELEMS * DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   prev_idx;
  logic            last;
  logic [VW-1:0]   sdata;
  logic [ADDR_W-1:0] step;

`ifdef VMEM_STRIDE_EN
  logic [7:0] stride_q;
  assign step = {{(ADDR_W-8){1'b0}}, stride_q};
`else
  assign step = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

  assign prev_idx = idx - 1'b1;
  assign last     = (idx == IW'(ELEMS - 1));

  // Sequencer: issues one access per cycle, read data lags by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      sdata         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      load_data     <= '0;
      mem.mem_addr  <= '0;
      mem.mem_re    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
`ifdef VMEM_STRIDE_EN
      stride_q      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            idx          <= '0;
            mem.mem_addr <= base_addr;
`ifdef VMEM_STRIDE_EN
            stride_q     <= stride;
`endif
            if (is_store) begin
              mem.mem_we    <= 1'b1;
              mem.mem_wdata <= store_data[DATA_W-1:0];
              sdata         <= store_data >> DATA_W;
              state         <= STORE;
            end else begin
              mem.mem_re <= 1'b1;
              state      <= LOAD;
            end
          end
        end
        STORE: begin
          if (last) begin
            mem.mem_we <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx           <= idx + 1'b1;
            mem.mem_addr  <= mem.mem_addr + step;
            mem.mem_wdata <= sdata[DATA_W-1:0];
            sdata         <= sdata >> DATA_W;
          end
        end
        LOAD: begin
          if (idx != '0)
            load_data[int'(prev_idx)*DATA_W +: DATA_W] <= mem.mem_rdata;
          if (last) begin
            mem.mem_re <= 1'b0;
            state      <= DRAIN;
          end else begin
            idx          <= idx + 1'b1;
            mem.mem_addr <= mem.mem_addr + step;
          end
        end
        DRAIN: begin
          load_data[int'(idx)*DATA_W +: DATA_W] <= mem.mem_rdata;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_unit.sv
// Scoreboard bench for vec_mem_unit with a 1-cycle synchronous memory.
// Stride tests run only when VMEM_STRIDE_EN is defined.
module tb_vec_mem_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int EL = 16;
  localparam int VW = AW * EL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          is_store = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [VW-1:0] store_data = '0;
  logic [7:0]    stride = 8'd1;
  logic          busy;
  logic          done;
  logic [VW-1:0] load_data;

  always #5 clk = ~clk;

  vec_mem_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  vec_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .ELEMS(EL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .store_data(store_data),
`ifdef VMEM_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .mem       (mif.master)
  );

  logic [DW-1:0] mem    [65536];
  logic [DW-1:0] shadow [65536];

  always @(posedge clk) begin
    if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
    if (mif.mem_re) mif.mem_rdata <= mem[mif.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [VW-1:0] got, logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } acc_t;

  typedef struct {
    int            cyc;
    bit            ld;
    logic [VW-1:0] vec;
  } dn_t;

  acc_t wr_q[$];
  acc_t rd_q[$];
  dn_t  dn_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int exp_end = 0;
  bit active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_op(input bit st, input logic [AW-1:0] base,
                       input logic [VW-1:0] data, input logic [7:0] strd);
    logic [AW-1:0] a;
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < EL; i++) begin
      a = base + AW'(i * int'(strd));
      if (st) begin
        wr_q.push_back('{a, data[i*DW +: DW], i + 1});
        shadow[a] = data[i*DW +: DW];
      end else begin
        rd_q.push_back('{a, '0, i + 1});
        v[i*DW +: DW] = shadow[a];
      end
    end
    exp_end = st ? EL + 1 : EL + 2;
    dn_q.push_back('{exp_end, !st, v});
    is_store   = st;
    base_addr  = base;
    store_data = data;
    stride     = strd;
    start      = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    active     = 1'b1;
    start      = 1'b0;
    is_store   = ~st;
    base_addr  = ~base;
    store_data = ~data;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (active && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("timeout", active, 1'b0);
    if (active) begin
      active = 1'b0;
      wr_q.delete();
      rd_q.delete();
      dn_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int   rel;
    bit   eb;
    acc_t e;
    dn_t  d;
    if (rst_n) begin
      rel = cyc - acc_cyc + 1;
      eb  = active && rel >= 1 && rel <= exp_end;
      check("excl", mif.mem_re & mif.mem_we, 1'b0);
      check("busy", busy, eb);
      if (mif.mem_we) begin
        if (wr_q.size() == 0) check("unexp_we", 1'b1, 1'b0);
        else begin
          e = wr_q.pop_front();
          check("w_addr", mif.mem_addr, e.addr);
          check("w_data", mif.mem_wdata, e.data);
          check("w_cyc", rel, e.cyc);
        end
      end
      if (mif.mem_re) begin
        if (rd_q.size() == 0) check("unexp_re", 1'b1, 1'b0);
        else begin
          e = rd_q.pop_front();
          check("r_addr", mif.mem_addr, e.addr);
          check("r_cyc", rel, e.cyc);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) check("unexp_done", 1'b1, 1'b0);
        else begin
          d = dn_q.pop_front();
          check("done_cyc", rel, d.cyc);
          if (d.ld) check("load_data", load_data, d.vec);
        end
        active = 1'b0;
      end
    end
  end

  logic [VW-1:0] vec_a;
  logic [VW-1:0] vec_w;
  logic [VW-1:0] vec_b;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = DW'(i) ^ 16'h5555;
      shadow[i] = DW'(i) ^ 16'h5555;
    end
    for (int i = 0; i < EL; i++) begin
      vec_a[i*DW +: DW] = 16'hA000 + DW'(i);
      vec_b[i*DW +: DW] = 16'hB000 + DW'(i);
      vec_w[i*DW +: DW] = DW'($urandom);
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ld", load_data, '0);
    check("rst_addr", mif.mem_addr, '0);
    check("rst_re", mif.mem_re, 1'b0);
    check("rst_we", mif.mem_we, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(1'b1, 16'h0100, vec_a, 8'd1);
    wait_done();
    do_op(1'b0, 16'h0200, '0, 8'd1);
    wait_done();

    do_op(1'b1, 16'hFFF8, vec_w, 8'd1);
    wait_done();
    do_op(1'b0, 16'hFFF8, '0, 8'd1);
    wait_done();
    check("wrap_vec", load_data, vec_w);

    do_op(1'b1, 16'h0500, vec_b, 8'd1);
    repeat (4) @(posedge clk);
    #1;
    is_store  = 1'b0;
    base_addr = 16'h0300;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    do_op(1'b0, 16'h0500, '0, 8'd1);
    wait_done();
    check("coll_vec", load_data, vec_b);

    do_op(1'b0, 16'h0200, '0, 8'd1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    wr_q.delete();
    rd_q.delete();
    dn_q.delete();
    active = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ld", load_data, '0);
    check("abort_addr", mif.mem_addr, '0);
    check("abort_re", mif.mem_re, 1'b0);
    check("abort_we", mif.mem_we, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ld2", load_data, '0);
    do_op(1'b1, 16'h0600, vec_a, 8'd1);
    wait_done();

`ifdef VMEM_STRIDE_EN
    do_op(1'b1, 16'h0010, vec_b, 8'd4);
    wait_done();
    do_op(1'b0, 16'h0010, '0, 8'd0);
    wait_done();
    do_op(1'b1, 16'h0700, vec_a, 8'd0);
    wait_done();
    do_op(1'b0, 16'h0700, '0, 8'd1);
    wait_done();
    check("s0_last", load_data[DW-1:0], 16'hA00F);
`endif

    check("q_empty", wr_q.size() + rd_q.size() + dn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
